// File: rtl/serial_word_tx.sv
// serial_word_tx: MSB-first 8-bit word serializer with optional gapped repeats
// and a saturating golden count of PATTERN occurrences in the emitted stream.
`default_nettype none

module serial_word_tx #(
  parameter int              GAP     = 2,
  parameter int              PLEN    = 5,
  parameter logic [PLEN-1:0] PATTERN = 5'b01011
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic [7:0] data_i,
  input  logic [2:0] rep_i,
  output logic       dout_o,
  output logic       dvalid_o,
  output logic [2:0] bit_idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] match_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
  localparam logic [3:0] PLEN_M1  = 4'(PLEN - 1);

  state_t            state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        rep_q, rep_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        gap_cnt_q, gap_cnt_d;
  logic [PLEN-1:0]   win_q, win_d;
  logic [3:0]        nsent_q, nsent_d;
  logic [2:0]        match_cnt_q, match_cnt_d;
  logic              dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic [2:0]        idx_out_q, idx_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PLEN-1:0]   win_shift;

  assign win_shift = {win_q[PLEN-2:0], data_q[bit_idx_q]};

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rep_d       = rep_q;
    bit_idx_d   = bit_idx_q;
    gap_cnt_d   = gap_cnt_q;
    win_d       = win_q;
    nsent_d     = nsent_q;
    match_cnt_d = match_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (set_i) begin
          state_d     = ST_SHIFT;
          data_d      = data_i;
          rep_d       = rep_i;
          bit_idx_d   = 3'd7;
          win_d       = '0;
          nsent_d     = 4'd0;
          match_cnt_d = 3'd0;
        end
      end
      ST_SHIFT: begin
        // Window advances only on valid bits, so it spans repetition boundaries.
        win_d = win_shift;
        if (nsent_q != 4'd8) nsent_d = nsent_q + 4'd1;
        if ((nsent_q >= PLEN_M1) && (win_shift == PATTERN) && (match_cnt_q != 3'd7))
          match_cnt_d = match_cnt_q + 3'd1;
        bit_idx_d = bit_idx_q - 3'd1;
        if (bit_idx_q == 3'd0) begin
          if (rep_q != 3'd0) begin
            if (GAP > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LAST;
            end else begin
              bit_idx_d = 3'd7;
              rep_d     = rep_q - 3'd1;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 3'd0) begin
          state_d   = ST_SHIFT;
          bit_idx_d = 3'd7;
          rep_d     = rep_q - 3'd1;
        end else begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are derived from next state so they appear registered.
    dvalid_d  = (state_d == ST_SHIFT);
    dout_d    = dvalid_d ? data_d[bit_idx_d] : 1'b0;
    idx_out_d = dvalid_d ? bit_idx_d : 3'd0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      rep_q       <= '0;
      bit_idx_q   <= '0;
      gap_cnt_q   <= '0;
      win_q       <= '0;
      nsent_q     <= '0;
      match_cnt_q <= '0;
      dout_q      <= 1'b0;
      dvalid_q    <= 1'b0;
      idx_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rep_q       <= rep_d;
      bit_idx_q   <= bit_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      win_q       <= win_d;
      nsent_q     <= nsent_d;
      match_cnt_q <= match_cnt_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      idx_out_q   <= idx_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dout_o      = dout_q;
  assign dvalid_o    = dvalid_q;
  assign bit_idx_o   = idx_out_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign match_cnt_o = match_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (GAP=2 and GAP=0) checked cycle by
// cycle against a stream-level reference model.
`default_nettype none

module tb_serial_word_tx;

  localparam int         PLEN    = 5;
  localparam logic [4:0] PATTERN = 5'b01011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_a = 1'b0;
  logic       set_b = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] rep = 3'd0;

  logic       dout_a, dvalid_a, busy_a, done_a;
  logic [2:0] idx_a, cnt_a;
  logic       dout_b, dvalid_b, busy_b, done_b;
  logic [2:0] idx_b, cnt_b;
  logic [9:0] vec_a, vec_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  serial_word_tx #(.GAP(2), .PLEN(PLEN), .PATTERN(PATTERN)) dut_a (
    .clk_i(clk), .rst_i(rst), .set_i(set_a), .data_i(data), .rep_i(rep),
    .dout_o(dout_a), .dvalid_o(dvalid_a), .bit_idx_o(idx_a),
    .busy_o(busy_a), .done_o(done_a), .match_cnt_o(cnt_a)
  );

  serial_word_tx #(.GAP(0), .PLEN(PLEN), .PATTERN(PATTERN)) dut_b (
    .clk_i(clk), .rst_i(rst), .set_i(set_b), .data_i(data), .rep_i(rep),
    .dout_o(dout_b), .dvalid_o(dvalid_b), .bit_idx_o(idx_b),
    .busy_o(busy_b), .done_o(done_b), .match_cnt_o(cnt_b)
  );

  // {busy, done, dvalid, dout, bit_idx[2:0], match_cnt[2:0]}
  assign vec_a = {busy_a, done_a, dvalid_a, dout_a, idx_a, cnt_a};
  assign vec_b = {busy_b, done_b, dvalid_b, dout_b, idx_b, cnt_b};

  // Expected per-cycle outputs from the cycle after acceptance up to and
  // including the first idle cycle after done.
  task automatic build_expected(input logic [7:0] d, input int r, input int g);
    bit hist[$];
    int cnt;
    bit hit;
    cnt = 0;
    exp_q.delete();
    for (int w = 0; w <= r; w++) begin
      for (int b = 7; b >= 0; b--) begin
        exp_q.push_back({1'b1, 1'b0, 1'b1, d[b], 3'(b), 3'(cnt)});
        hist.push_back(d[b]);
        if (hist.size() >= PLEN) begin
          hit = 1'b1;
          for (int j = 0; j < PLEN; j++)
            if (hist[hist.size() - PLEN + j] != PATTERN[PLEN-1-j]) hit = 1'b0;
          if (hit && cnt < 7) cnt++;
        end
      end
      if (w < r)
        for (int k = 0; k < g; k++) exp_q.push_back({4'b1000, 3'd0, 3'(cnt)});
    end
    exp_q.push_back({4'b1100, 3'd0, 3'(cnt)});
    exp_q.push_back({4'b0000, 3'd0, 3'(cnt)});
  endtask

  // Starts a transfer and checks every cycle. noisy keeps set_i high with junk
  // data while busy; abort_at >= 0 applies reset at that cycle's closing edge.
  task automatic run_xfer(input bit use_b, input logic [7:0] d, input logic [2:0] r,
                          input bit noisy, input int abort_at, input string name);
    logic [9:0] obs;
    int n;
    build_expected(d, int'(r), use_b ? 0 : 2);
    n = exp_q.size();
    data = d;
    rep  = r;
    if (use_b) set_b = 1'b1; else set_a = 1'b1;
    @(posedge clk); #1;
    set_a = 1'b0;
    set_b = 1'b0;
    data  = 8'($urandom);
    rep   = 3'($urandom);
    for (int k = 0; k < n; k++) begin
      obs = use_b ? vec_b : vec_a;
      n_cmp++;
      if (obs !== exp_q[k]) begin
        n_err++;
        $display("FAIL %s cyc %0d: got %b expected %b", name, k, obs, exp_q[k]);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
          obs = use_b ? vec_b : vec_a;
          n_cmp++;
          if (obs !== 10'd0) begin
            n_err++;
            $display("FAIL %s after_reset %0d: got %b expected %b", name, c, obs, 10'd0);
          end
          if (c == 0) begin
            @(posedge clk); #1;
          end
        end
        return;
      end
      if (k < n - 1) begin
        if (noisy) begin
          if (use_b) set_b = 1'b1; else set_a = 1'b1;
          data = 8'hFF;
          rep  = 3'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    set_a = 1'b0;
    set_b = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    set_a = 1'b1;
    set_b = 1'b1;
    data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (vec_a !== 10'd0) begin
      n_err++;
      $display("FAIL reset_a: got %b expected %b", vec_a, 10'd0);
    end
    n_cmp++;
    if (vec_b !== 10'd0) begin
      n_err++;
      $display("FAIL reset_b: got %b expected %b", vec_b, 10'd0);
    end
    rst   = 1'b0;
    set_a = 1'b0;
    set_b = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (vec_a !== 10'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b expected %b", vec_a, 10'd0);
    end
  endtask

  task automatic test_single();
    run_xfer(1'b0, 8'hA5, 3'd0, 1'b0, -1, "single_a5");
  endtask

  task automatic test_pattern();
    run_xfer(1'b0, 8'h2C, 3'd0, 1'b0, -1, "pattern_2c");
  endtask

  task automatic test_repeat_gap();
    run_xfer(1'b0, 8'h2C, 3'd1, 1'b0, -1, "repeat_gap");
  endtask

  task automatic test_saturation();
    run_xfer(1'b1, 8'h5A, 3'd7, 1'b0, -1, "saturation");
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b0, 8'hA5, 3'd1, 1'b1, -1, "ignored_start");
    run_xfer(1'b0, 8'($urandom), 3'd0, 1'b0, -1, "back_to_back");
  endtask

  task automatic test_reset_mid();
    run_xfer(1'b0, 8'hA5, 3'd0, 1'b0, 4, "reset_mid");
    run_xfer(1'b0, 8'($urandom), 3'd0, 1'b0, -1, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_xfer(1'b0, 8'($urandom), 3'($urandom), 1'($urandom), -1, "rand_gap2");
    for (int i = 0; i < 4; i++)
      run_xfer(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), -1, "rand_gap0");
  endtask

  initial begin
    test_reset();
    test_single();
    test_pattern();
    test_repeat_gap();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
